// File: rtl/mem_wb_multi.sv
// Multi-lane MEM->WB pipeline register with in-order exception/ERTN arbitration and CSR trap interface.
// Latency: 1 cycle for writeback/commit registers; trap/ERTN interface is combinational from MEM.
// Backpressure: stall holds WB data and inserts a bubble with no trap; flush clears all lanes.
module mem_wb_multi #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int EXCP_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [LANES-1:0]           mem_valid,
  input  logic [LANES*RADDR_W-1:0]   mem_wd,
  input  logic [LANES-1:0]           mem_wreg,
  input  logic [LANES*DATA_W-1:0]    mem_wdata,
  input  logic [LANES*DATA_W-1:0]    mem_pc,
  input  logic [LANES*32-1:0]        mem_instr,
  input  logic [LANES*DATA_W-1:0]    mem_vaddr,
  input  logic [LANES*EXCP_W-1:0]    mem_excp_num,
  input  logic [LANES-1:0]           mem_ertn,
  input  logic [LANES-1:0]           mem_csr_we,
  input  logic [LANES*14-1:0]        mem_csr_addr,
  input  logic [LANES*DATA_W-1:0]    mem_csr_data,
  input  logic [LANES-1:0]           mem_llbit_we,
  input  logic [LANES-1:0]           mem_llbit_value,
  output logic [LANES-1:0]           wb_valid,
  output logic [LANES*RADDR_W-1:0]   wb_wd,
  output logic [LANES-1:0]           wb_wreg,
  output logic [LANES*DATA_W-1:0]    wb_wdata,
  output logic [LANES-1:0]           wb_csr_we,
  output logic [LANES*14-1:0]        wb_csr_addr,
  output logic [LANES*DATA_W-1:0]    wb_csr_data,
  output logic [LANES-1:0]           wb_llbit_we,
  output logic [LANES-1:0]           wb_llbit_value,
  output logic [LANES-1:0]           debug_commit_valid,
  output logic [LANES*DATA_W-1:0]    debug_commit_pc,
  output logic [LANES*32-1:0]        debug_commit_instr,
  output logic                       excp_flush,
  output logic                       ertn_flush,
  output logic [DATA_W-1:0]          csr_era,
  output logic [5:0]                 csr_ecode,
  output logic [8:0]                 csr_esubcode,
  output logic                       va_error,
  output logic [DATA_W-1:0]          bad_va,
  output logic                       excp_tlb,
  output logic                       excp_tlbrefill,
  output logic [18:0]                excp_tlb_vppn,
  output logic [31:0]                retire_cnt,
  output logic [31:0]                trap_cnt
);

  // Trap lane index needs to represent LANES itself, meaning "no trapping lane".
  localparam int TW = $clog2(LANES + 1);

  logic            go;
  logic            advance;
  logic [LANES-1:0] lane_live;
  logic [LANES-1:0] commit_mask;
  logic [TW-1:0]   trap_lane;
  logic            has_trap;
  logic [EXCP_W-1:0] t_excp;
  logic            t_ertn;
  logic [DATA_W-1:0] t_pc;
  logic [DATA_W-1:0] t_vaddr;
  logic [15:0]     excp16;
  logic [3:0]      cause_idx;
  logic            fetch_side;
  logic            data_side;
  logic [31:0]     retire_inc;
  logic [31:0]     retire_q;
  logic [31:0]     trap_q;

  assign go      = ~stall & ~flush & ~rst;
  assign advance = ~stall & ~flush;

  // A lane is a trap candidate when it is valid and carries an exception or ERTN.
  always_comb begin
    lane_live = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_live[i] = mem_valid[i] & ((|mem_excp_num[i*EXCP_W +: EXCP_W]) | mem_ertn[i]);
    end
  end

  // Oldest candidate wins; lanes older than it commit, it and younger lanes are squashed.
  always_comb begin
    trap_lane = TW'(LANES);
    has_trap  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_live[i]) begin
        trap_lane = TW'(i);
        has_trap  = 1'b1;
      end
    end
  end

  // Committing lanes and their count for the retire counter.
  always_comb begin
    commit_mask = '0;
    retire_inc  = '0;
    for (int i = 0; i < LANES; i++) begin
      commit_mask[i] = mem_valid[i] & (TW'(i) < trap_lane);
      retire_inc     = retire_inc + 32'(commit_mask[i]);
    end
  end

  // Select the trapping lane's cause vector, ERTN flag, PC and data address.
  always_comb begin
    t_excp  = '0;
    t_ertn  = 1'b0;
    t_pc    = '0;
    t_vaddr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (has_trap && (TW'(i) == trap_lane)) begin
        t_excp  = mem_excp_num[i*EXCP_W +: EXCP_W];
        t_ertn  = mem_ertn[i];
        t_pc    = mem_pc[i*DATA_W +: DATA_W];
        t_vaddr = mem_vaddr[i*DATA_W +: DATA_W];
      end
    end
  end

  // Exception beats ERTN when both sit in the trapping lane; nothing fires while stalled/flushed.
  assign excp_flush = go & has_trap & (|t_excp);
  assign ertn_flush = go & has_trap & t_ertn & ~(|t_excp);

  // Lowest set cause bit is the highest-priority cause.
  always_comb begin
    excp16    = 16'(t_excp);
    cause_idx = 4'd0;
    for (int b = 15; b >= 0; b--) begin
      if (excp16[b]) cause_idx = 4'(b);
    end
  end

  assign fetch_side = (cause_idx >= 4'd1) && (cause_idx <= 4'd4);
  assign data_side  = (cause_idx >= 4'd9);

  // Decode cause into CSR trap information; all zero unless an exception is taken.
  always_comb begin
    csr_era        = '0;
    csr_ecode      = '0;
    csr_esubcode   = '0;
    va_error       = 1'b0;
    bad_va         = '0;
    excp_tlb       = 1'b0;
    excp_tlbrefill = 1'b0;
    excp_tlb_vppn  = '0;
    if (excp_flush) begin
      csr_era = t_pc;
      case (cause_idx)
        4'd0:    csr_ecode = 6'h00; // INT
        4'd1:    csr_ecode = 6'h08; // ADEF
        4'd2:    csr_ecode = 6'h3F; // TLBR (fetch)
        4'd3:    csr_ecode = 6'h03; // PIF
        4'd4:    csr_ecode = 6'h07; // PPI (fetch)
        4'd5:    csr_ecode = 6'h0B; // SYS
        4'd6:    csr_ecode = 6'h0C; // BRK
        4'd7:    csr_ecode = 6'h0D; // INE
        4'd8:    csr_ecode = 6'h0E; // IPE
        4'd9:    csr_ecode = 6'h09; // ALE
        4'd10:   csr_ecode = 6'h08; // ADEM
        4'd11:   csr_ecode = 6'h3F; // TLBR (data)
        4'd12:   csr_ecode = 6'h04; // PME
        4'd13:   csr_ecode = 6'h07; // PPI (data)
        4'd14:   csr_ecode = 6'h02; // PIS
        default: csr_ecode = 6'h01; // PIL
      endcase
      csr_esubcode   = (cause_idx == 4'd10) ? 9'd1 : 9'd0;
      va_error       = fetch_side | data_side;
      bad_va         = fetch_side ? t_pc : (data_side ? t_vaddr : '0);
      excp_tlb       = ((cause_idx >= 4'd2) && (cause_idx <= 4'd4)) || (cause_idx >= 4'd11);
      excp_tlbrefill = (cause_idx == 4'd2) || (cause_idx == 4'd11);
      excp_tlb_vppn  = fetch_side ? t_pc[31:13] : (data_side ? t_vaddr[31:13] : 19'd0);
    end
  end

  // WB register: reset/flush clear everything, stall bubbles but keeps data, else load MEM.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_valid           <= '0;
      wb_wd              <= '0;
      wb_wreg            <= '0;
      wb_wdata           <= '0;
      wb_csr_we          <= '0;
      wb_csr_addr        <= '0;
      wb_csr_data        <= '0;
      wb_llbit_we        <= '0;
      wb_llbit_value     <= '0;
      debug_commit_valid <= '0;
      debug_commit_pc    <= '0;
      debug_commit_instr <= '0;
    end else if (stall) begin
      wb_valid           <= '0;
      wb_wreg            <= '0;
      wb_csr_we          <= '0;
      wb_llbit_we        <= '0;
      debug_commit_valid <= '0;
    end else begin
      wb_valid           <= commit_mask;
      wb_wd              <= mem_wd;
      wb_wreg            <= mem_wreg & commit_mask;
      wb_wdata           <= mem_wdata;
      wb_csr_we          <= mem_csr_we & commit_mask;
      wb_csr_addr        <= mem_csr_addr;
      wb_csr_data        <= mem_csr_data;
      wb_llbit_we        <= mem_llbit_we & commit_mask;
      wb_llbit_value     <= mem_llbit_value;
      debug_commit_valid <= commit_mask;
      debug_commit_pc    <= mem_pc;
      debug_commit_instr <= mem_instr;
    end
  end

  // Wrapping retire/trap performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
      trap_q   <= '0;
    end else begin
      if (advance) retire_q <= retire_q + retire_inc;
      if (excp_flush || ertn_flush) trap_q <= trap_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
  assign trap_cnt   = trap_q;

endmodule

// File: tb/tb_mem_wb_multi.sv
// Directed bench for mem_wb_multi: commit/squash, cause decode, stall/flush/reset, counter wrap.
// Inputs change on the falling edge; comb outputs checked before the rising edge, registers after.
// Each lane's writeback fields are derived from its PC so expectations follow from the vector.
module tb_mem_wb_multi;
  localparam int L  = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int EW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush;
  logic [L-1:0]    mem_valid, mem_wreg, mem_ertn, mem_csr_we, mem_llbit_we, mem_llbit_value;
  logic [L*RW-1:0] mem_wd;
  logic [L*DW-1:0] mem_wdata, mem_pc, mem_vaddr, mem_csr_data;
  logic [L*32-1:0] mem_instr;
  logic [L*EW-1:0] mem_excp_num;
  logic [L*14-1:0] mem_csr_addr;
  logic [L-1:0]    wb_valid, wb_wreg, wb_csr_we, wb_llbit_we, wb_llbit_value, debug_commit_valid;
  logic [L*RW-1:0] wb_wd;
  logic [L*DW-1:0] wb_wdata, wb_csr_data, debug_commit_pc;
  logic [L*14-1:0] wb_csr_addr;
  logic [L*32-1:0] debug_commit_instr;
  logic            excp_flush, ertn_flush, va_error, excp_tlb, excp_tlbrefill;
  logic [DW-1:0]   csr_era, bad_va;
  logic [5:0]      csr_ecode;
  logic [8:0]      csr_esubcode;
  logic [18:0]     excp_tlb_vppn;
  logic [31:0]     retire_cnt, trap_cnt;

  mem_wb_multi #(.LANES(L), .DATA_W(DW), .RADDR_W(RW), .EXCP_W(EW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_vaddr(mem_vaddr), .mem_excp_num(mem_excp_num),
    .mem_ertn(mem_ertn), .mem_csr_we(mem_csr_we), .mem_csr_addr(mem_csr_addr),
    .mem_csr_data(mem_csr_data), .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr), .wb_csr_data(wb_csr_data),
    .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
    .debug_commit_valid(debug_commit_valid), .debug_commit_pc(debug_commit_pc),
    .debug_commit_instr(debug_commit_instr),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .csr_era(csr_era), .csr_ecode(csr_ecode),
    .csr_esubcode(csr_esubcode), .va_error(va_error), .bad_va(bad_va), .excp_tlb(excp_tlb),
    .excp_tlbrefill(excp_tlbrefill), .excp_tlb_vppn(excp_tlb_vppn),
    .retire_cnt(retire_cnt), .trap_cnt(trap_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    stall = 1'b0; flush = 1'b0;
    mem_valid = '0; mem_wd = '0; mem_wreg = '0; mem_wdata = '0; mem_pc = '0; mem_instr = '0;
    mem_vaddr = '0; mem_excp_num = '0; mem_ertn = '0; mem_csr_we = '0; mem_csr_addr = '0;
    mem_csr_data = '0; mem_llbit_we = '0; mem_llbit_value = '0;
  endtask

  // Valid lane; wd = i+3, wdata = pc+0x1000_0000, instr = pc^0x0200_0000, csr addr 0x10+i.
  task automatic set_lane(input int i, input logic [31:0] pc, input logic [15:0] excp,
                          input logic ertn, input logic [31:0] vaddr);
    mem_valid[i]             = 1'b1;
    mem_pc[i*DW +: DW]       = pc;
    mem_instr[i*32 +: 32]    = pc ^ 32'h0200_0000;
    mem_wd[i*RW +: RW]       = RW'(i + 3);
    mem_wreg[i]              = 1'b1;
    mem_wdata[i*DW +: DW]    = pc + 32'h1000_0000;
    mem_vaddr[i*DW +: DW]    = vaddr;
    mem_excp_num[i*EW +: EW] = excp;
    mem_ertn[i]              = ertn;
    mem_csr_we[i]            = 1'b1;
    mem_csr_addr[i*14 +: 14] = 14'(16 + i);
    mem_csr_data[i*DW +: DW] = pc + 32'h2000_0000;
    mem_llbit_we[i]          = 1'b1;
    mem_llbit_value[i]       = 1'(i);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with a trapping instruction present: nothing may leak out.
    idle_all();
    rst = 1'b1;
    set_lane(0, 32'h0000_0100, 16'h0020, 1'b0, 32'h0);
    set_lane(1, 32'h0000_0104, 16'h0000, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    check("rst_no_excp", excp_flush, 1'b0);
    step();
    check("rst_valid", wb_valid, 2'b00);
    check("rst_wdata", wb_wdata, 64'h0);
    check("rst_pc", debug_commit_pc, 64'h0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_trap", trap_cnt, 32'd0);
    rst = 1'b0;

    // 1: both lanes clean.
    idle_all();
    set_lane(0, 32'h0000_1000, 16'h0000, 1'b0, 32'h0);
    set_lane(1, 32'h0000_1004, 16'h0000, 1'b0, 32'h0);
    #1;
    check("t1_excp", excp_flush, 1'b0);
    step();
    check("t1_valid", wb_valid, 2'b11);
    check("t1_commit", debug_commit_valid, 2'b11);
    check("t1_wreg", wb_wreg, 2'b11);
    check("t1_wd", wb_wd, 10'h083);
    check("t1_wdata", wb_wdata, 64'h1000_1004_1000_1000);
    check("t1_pc", debug_commit_pc, 64'h0000_1004_0000_1000);
    check("t1_instr", debug_commit_instr, 64'h0200_1004_0200_1000);
    check("t1_llv", wb_llbit_value, 2'b10);
    check("t1_retire", retire_cnt, 32'd2);

    // 2: SYS in lane 1; lane 0 commits.
    idle_all();
    set_lane(0, 32'h0000_2000, 16'h0000, 1'b0, 32'h0);
    set_lane(1, 32'h0000_2004, 16'h0020, 1'b0, 32'h0);
    #1;
    check("t2_excp", excp_flush, 1'b1);
    check("t2_ertn", ertn_flush, 1'b0);
    check("t2_ecode", csr_ecode, 6'h0B);
    check("t2_era", csr_era, 32'h0000_2004);
    check("t2_vaerr", va_error, 1'b0);
    step();
    check("t2_valid", wb_valid, 2'b01);
    check("t2_csrwe", wb_csr_we, 2'b01);
    check("t2_retire", retire_cnt, 32'd3);
    check("t2_trap", trap_cnt, 32'd1);

    // 3: INT+ALE in lane 0: INT wins, nothing commits.
    idle_all();
    set_lane(0, 32'h0000_3000, 16'h0201, 1'b0, 32'h0000_5555);
    set_lane(1, 32'h0000_3004, 16'h0000, 1'b0, 32'h0);
    #1;
    check("t3_ecode", csr_ecode, 6'h00);
    check("t3_vaerr", va_error, 1'b0);
    check("t3_badva", bad_va, 32'h0);
    check("t3_era", csr_era, 32'h0000_3000);
    step();
    check("t3_valid", wb_valid, 2'b00);
    check("t3_retire", retire_cnt, 32'd3);
    check("t3_trap", trap_cnt, 32'd2);

    // 4: ALE in lane 0, then the same inputs stalled.
    idle_all();
    set_lane(0, 32'h0000_4000, 16'h0200, 1'b0, 32'h8000_1003);
    set_lane(1, 32'h0000_4004, 16'h0000, 1'b0, 32'h0);
    #1;
    check("t4_ecode", csr_ecode, 6'h09);
    check("t4_badva", bad_va, 32'h8000_1003);
    check("t4_vaerr", va_error, 1'b1);
    check("t4_tlb", excp_tlb, 1'b0);
    step();
    check("t4_wreg", wb_wreg, 2'b00);
    check("t4_wdata", wb_wdata, 64'h1000_4004_1000_4000);
    check("t4_trap", trap_cnt, 32'd3);
    stall = 1'b1;
    mem_wdata = 64'hDEAD_0001_DEAD_0000;
    #1;
    check("t4s_excp", excp_flush, 1'b0);
    check("t4s_badva", bad_va, 32'h0);
    step();
    check("t4s_valid", wb_valid, 2'b00);
    check("t4s_hold", wb_wdata, 64'h1000_4004_1000_4000);
    check("t4s_trap", trap_cnt, 32'd3);

    // Data-side TLB refill in lane 1.
    idle_all();
    set_lane(0, 32'h0000_6000, 16'h0000, 1'b0, 32'h0);
    set_lane(1, 32'h0000_6004, 16'h0800, 1'b0, 32'h1234_6000);
    #1;
    check("tlbr_ecode", csr_ecode, 6'h3F);
    check("tlbr_tlb", excp_tlb, 1'b1);
    check("tlbr_refill", excp_tlbrefill, 1'b1);
    check("tlbr_vppn", excp_tlb_vppn, 19'h091A3);
    check("tlbr_badva", bad_va, 32'h1234_6000);
    step();
    check("tlbr_retire", retire_cnt, 32'd4);

    // ADEM subcode.
    idle_all();
    set_lane(0, 32'h0000_6100, 16'h0400, 1'b0, 32'hDEAD_BEEC);
    #1;
    check("adem_ecode", csr_ecode, 6'h08);
    check("adem_sub", csr_esubcode, 9'd1);
    check("adem_badva", bad_va, 32'hDEAD_BEEC);
    step();

    // ADEF: fetch-side address from PC.
    idle_all();
    set_lane(0, 32'h7FFF_0002, 16'h0002, 1'b0, 32'h0000_1111);
    #1;
    check("adef_ecode", csr_ecode, 6'h08);
    check("adef_sub", csr_esubcode, 9'd0);
    check("adef_badva", bad_va, 32'h7FFF_0002);
    check("adef_vppn", excp_tlb_vppn, 19'h3FFF8);
    step();
    check("adef_trap", trap_cnt, 32'd6);

    // 5: ERTN with INE in the same lane: exception wins.
    idle_all();
    set_lane(0, 32'h0000_5000, 16'h0080, 1'b1, 32'h0);
    #1;
    check("t5_excp", excp_flush, 1'b1);
    check("t5_ertn", ertn_flush, 1'b0);
    check("t5_ecode", csr_ecode, 6'h0D);
    step();

    // Plain ERTN in lane 1; trap info stays zero.
    idle_all();
    set_lane(0, 32'h0000_5100, 16'h0000, 1'b0, 32'h0);
    set_lane(1, 32'h0000_5104, 16'h0000, 1'b1, 32'h0);
    #1;
    check("ertn_flush", ertn_flush, 1'b1);
    check("ertn_excp", excp_flush, 1'b0);
    check("ertn_era", csr_era, 32'h0);
    step();
    check("ertn_valid", wb_valid, 2'b01);
    check("ertn_retire", retire_cnt, 32'd5);
    check("ertn_trap", trap_cnt, 32'd8);

    // External flush with a trap pending.
    idle_all();
    set_lane(0, 32'h0000_5200, 16'h0000, 1'b0, 32'h0);
    set_lane(1, 32'h0000_5204, 16'h0020, 1'b0, 32'h0);
    flush = 1'b1;
    #1;
    check("fl_excp", excp_flush, 1'b0);
    step();
    check("fl_valid", wb_valid, 2'b00);
    check("fl_wdata", wb_wdata, 64'h0);
    check("fl_retire", retire_cnt, 32'd5);
    check("fl_trap", trap_cnt, 32'd8);

    // 6: retire counter wraps.
    idle_all();
    dut.retire_q = 32'hFFFF_FFFF;
    set_lane(0, 32'h0000_7000, 16'h0000, 1'b0, 32'h0);
    set_lane(1, 32'h0000_7004, 16'h0000, 1'b0, 32'h0);
    step();
    check("wrap_retire", retire_cnt, 32'd1);
    check("wrap_valid", wb_valid, 2'b11);

    // Reset in the middle of traffic.
    rst = 1'b1;
    step();
    check("mrst_valid", wb_valid, 2'b00);
    check("mrst_pc", debug_commit_pc, 64'h0);
    check("mrst_csrdat", wb_csr_data, 64'h0);
    check("mrst_retire", retire_cnt, 32'd0);
    check("mrst_trap", trap_cnt, 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
